// File: rtl/ex_stage_pkg.sv
// Shared definitions for the 16-bit pipeline: opcode map and the exec state value.
package ex_stage_pkg;

    typedef enum logic [4:0] {
        OP_NOP   = 5'd0,  OP_HALT  = 5'd1,  OP_LOAD  = 5'd2,  OP_STORE = 5'd3,
        OP_LDIH  = 5'd4,  OP_ADD   = 5'd5,  OP_ADDI  = 5'd6,  OP_ADDC  = 5'd7,
        OP_SUB   = 5'd8,  OP_SUBI  = 5'd9,  OP_SUBC  = 5'd10, OP_CMP   = 5'd11,
        OP_AND   = 5'd12, OP_OR    = 5'd13, OP_XOR   = 5'd14, OP_SLL   = 5'd15,
        OP_SRL   = 5'd16, OP_SLA   = 5'd17, OP_SRA   = 5'd18, OP_JUMP  = 5'd19,
        OP_JMPR  = 5'd20, OP_BZ    = 5'd21, OP_BNZ   = 5'd22, OP_BN    = 5'd23,
        OP_BNN   = 5'd24, OP_BC    = 5'd25, OP_BNC   = 5'd26
    } opcode_e;

    localparam logic STATE_EXEC = 1'b1;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU for the execute stage; add/sub done 17 bits wide, bit 16 is carry/borrow.
module ex_alu
    import ex_stage_pkg::*;
(
    input  logic [4:0]  opcode,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cf,
    output logic [15:0] result,
    output logic        cout
);
    logic [16:0] sum17;
    logic [16:0] wide;
    logic [15:0] shl;
    logic [3:0]  sh;

    always_comb begin
        sh     = b[3:0];
        shl    = a << sh;
        sum17  = 17'd0;
        wide   = 17'd0;
        result = 16'h0000;
        cout   = 1'b0;
        case (opcode_e'(opcode))
            OP_ADD, OP_ADDI, OP_LDIH, OP_LOAD, OP_STORE, OP_JMPR,
            OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC:
                wide = {1'b0, a} + {1'b0, b};
            OP_ADDC: wide = {1'b0, a} + {1'b0, b} + {16'd0, cf};
            OP_SUB, OP_SUBI, OP_CMP: wide = {1'b0, a} - {1'b0, b};
            // Bit 16 of the 17-bit difference is set exactly when the unsigned result underflows.
            OP_SUBC: wide = {1'b0, a} - {1'b0, b} - {16'd0, cf};
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_XOR:  wide = {1'b0, a ^ b};
            OP_SLL:  wide = {1'b0, shl};
            OP_SRL:  wide = {1'b0, a >> sh};
            OP_SLA:  wide = {1'b0, a[15], shl[14:0]};
            OP_SRA:  wide = {1'b0, $signed(a) >>> sh};
            default: wide = 17'd0;
        endcase
        sum17  = wide;
        result = sum17[15:0];
        cout   = sum17[16];
    end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, condition flags, branch decision and EX/MEM pipeline latches.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        state,
    input  logic [15:0] ex_ir,
    input  logic [15:0] reg_A,
    input  logic [15:0] reg_B,
    input  logic [15:0] smdr,
    output logic [15:0] ALUo,
    output logic        branch_taken,
    output logic [15:0] branch_target,
    output logic [15:0] mem_ir,
    output logic [15:0] reg_C,
    output logic [15:0] smdr1,
    output logic        dw,
    output logic        zf,
    output logic        nf,
    output logic        cf
);
    logic [15:0] mem_ir_q, mem_ir_d, reg_c_q, reg_c_d, smdr1_q, smdr1_d;
    logic        dw_q, dw_d, zf_q, zf_d, nf_q, nf_d, cf_q, cf_d;
    logic        alu_cout, advance;
    opcode_e     op;

    assign op = opcode_e'(ex_ir[15:11]);

    ex_alu u_alu (
        .opcode (ex_ir[15:11]),
        .a      (reg_A),
        .b      (reg_B),
        .cf     (cf_q),
        .result (ALUo),
        .cout   (alu_cout)
    );

    always_comb begin
        advance  = (state == STATE_EXEC);
        mem_ir_d = mem_ir_q;
        reg_c_d  = reg_c_q;
        smdr1_d  = smdr1_q;
        dw_d     = dw_q;
        zf_d     = zf_q;
        nf_d     = nf_q;
        cf_d     = cf_q;
        if (advance) begin
            mem_ir_d = ex_ir;
            reg_c_d  = ALUo;
            smdr1_d  = smdr;
            dw_d     = (op == OP_STORE);
            case (op)
                OP_ADD, OP_ADDC, OP_ADDI, OP_SUB, OP_SUBC, OP_SUBI, OP_CMP: begin
                    zf_d = (ALUo == 16'h0000);
                    nf_d = ALUo[15];
                    cf_d = alu_cout;
                end
                OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLA, OP_SRA: begin
                    zf_d = (ALUo == 16'h0000);
                    nf_d = ALUo[15];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        branch_taken = 1'b0;
        case (op)
            OP_BZ:   branch_taken = zf_q;
            OP_BNZ:  branch_taken = !zf_q;
            OP_BN:   branch_taken = nf_q;
            OP_BNN:  branch_taken = !nf_q;
            OP_BC:   branch_taken = cf_q;
            OP_BNC:  branch_taken = !cf_q;
            OP_JMPR: branch_taken = 1'b1;
            default: branch_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_ir_q <= 16'h0000;
            reg_c_q  <= 16'h0000;
            smdr1_q  <= 16'h0000;
            dw_q     <= 1'b0;
            zf_q     <= 1'b0;
            nf_q     <= 1'b0;
            cf_q     <= 1'b0;
        end else begin
            mem_ir_q <= mem_ir_d;
            reg_c_q  <= reg_c_d;
            smdr1_q  <= smdr1_d;
            dw_q     <= dw_d;
            zf_q     <= zf_d;
            nf_q     <= nf_d;
            cf_q     <= cf_d;
        end
    end

    assign branch_target = ALUo;
    assign mem_ir        = mem_ir_q;
    assign reg_C         = reg_c_q;
    assign smdr1         = smdr1_q;
    assign dw            = dw_q;
    assign zf            = zf_q;
    assign nf            = nf_q;
    assign cf            = cf_q;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: hand-computed vectors checked with immediate assertions.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clock = 1'b0;
    logic        reset, state;
    logic [15:0] ex_ir, reg_A, reg_B, smdr;
    logic [15:0] ALUo, branch_target, mem_ir, reg_C, smdr1;
    logic        branch_taken, dw, zf, nf, cf;

    int errors = 0;
    int checks = 0;

    ex_stage dut (
        .clock(clock), .reset(reset), .state(state), .ex_ir(ex_ir),
        .reg_A(reg_A), .reg_B(reg_B), .smdr(smdr), .ALUo(ALUo),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .mem_ir(mem_ir), .reg_C(reg_C), .smdr1(smdr1), .dw(dw),
        .zf(zf), .nf(nf), .cf(cf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input opcode_e op, input logic [15:0] a, input logic [15:0] b);
        ex_ir = {op, 11'h0A5};
        reg_A = a;
        reg_B = b;
    endtask

    initial begin
        state = STATE_EXEC;
        reset = 1'b1;
        smdr  = 16'h0000;
        drive(OP_ADD, 16'h0000, 16'h0000);

        // Reset with random inputs: everything registered stays zero.
        for (int i = 0; i < 2; i++) begin
            ex_ir = 16'($urandom); reg_A = 16'($urandom);
            reg_B = 16'($urandom); smdr  = 16'($urandom);
            step();
            chk("rst_mem_ir", mem_ir, 16'h0000);
            chk("rst_reg_C", reg_C, 16'h0000);
            chk("rst_smdr1", smdr1, 16'h0000);
            chk("rst_flags_dw", {12'd0, dw, zf, nf, cf}, 16'h0000);
        end
        reset = 1'b0;
        smdr  = 16'h1234;

        // ADD overflow to zero.
        drive(OP_ADD, 16'hFFFF, 16'h0001);
        #1;
        chk("add_aluo", ALUo, 16'h0000);
        chk("add_bt", {15'd0, branch_taken}, 16'h0000);
        step();
        chk("add_flags", {13'd0, zf, nf, cf}, 16'h0005);
        chk("add_reg_C", reg_C, 16'h0000);
        chk("add_mem_ir", mem_ir, {OP_ADD, 11'h0A5});
        chk("add_smdr1", smdr1, 16'h1234);

        // SUB with borrow, then SUBC consumes it.
        drive(OP_SUB, 16'h0003, 16'h0005);
        step();
        chk("sub_reg_C", reg_C, 16'hFFFE);
        chk("sub_flags", {13'd0, zf, nf, cf}, 16'h0003);
        drive(OP_SUBC, 16'h0010, 16'h0001);
        #1;
        chk("subc_aluo", ALUo, 16'h000E);
        step();
        chk("subc_reg_C", reg_C, 16'h000E);
        chk("subc_flags", {13'd0, zf, nf, cf}, 16'h0000);

        // Carry out of ADD, then shifts must leave cf alone.
        drive(OP_ADD, 16'hFFFF, 16'h0002);
        step();
        chk("add2_flags", {13'd0, zf, nf, cf}, 16'h0001);
        drive(OP_SRA, 16'h8000, 16'h0004);
        #1;
        chk("sra_aluo", ALUo, 16'hF800);
        step();
        chk("sra_flags", {13'd0, zf, nf, cf}, 16'h0003);
        drive(OP_SLA, 16'h8001, 16'h0001);
        step();
        chk("sla_reg_C", reg_C, 16'h8002);
        drive(OP_SRL, 16'h8000, 16'h0004);
        #1;
        chk("srl_aluo", ALUo, 16'h0800);
        drive(OP_SLL, 16'h8001, 16'h0001);
        #1;
        chk("sll_aluo", ALUo, 16'h0002);
        drive(OP_AND, 16'hF0F0, 16'h0F0F);
        step();
        chk("and_flags", {13'd0, zf, nf, cf}, 16'h0005);
        drive(OP_XOR, 16'hF0F0, 16'h0FF0);
        #1;
        chk("xor_aluo", ALUo, 16'hFF00);
        drive(OP_HALT, 16'h1111, 16'h2222);
        #1;
        chk("other_aluo", ALUo, 16'h0000);

        // CMP equal, then BZ taken, BNZ not taken.
        drive(OP_CMP, 16'h0007, 16'h0007);
        step();
        chk("cmp_flags", {13'd0, zf, nf, cf}, 16'h0004);
        drive(OP_BZ, 16'h0100, 16'h0004);
        #1;
        chk("bz_bt", {15'd0, branch_taken}, 16'h0001);
        chk("bz_target", branch_target, 16'h0104);
        step();
        drive(OP_BNZ, 16'h0100, 16'h0004);
        #1;
        chk("bnz_bt", {15'd0, branch_taken}, 16'h0000);
        drive(OP_BNC, 16'h0000, 16'h0000);
        #1;
        chk("bnc_bt", {15'd0, branch_taken}, 16'h0001);
        drive(OP_BC, 16'h0000, 16'h0000);
        #1;
        chk("bc_bt", {15'd0, branch_taken}, 16'h0000);
        drive(OP_JMPR, 16'h0200, 16'h0003);
        #1;
        chk("jmpr_bt", {15'd0, branch_taken}, 16'h0001);
        chk("jmpr_target", branch_target, 16'h0203);

        // Bubble after a flag setter leaves the flags intact.
        drive(OP_SUB, 16'h0001, 16'h0002);
        step();
        ex_ir = 16'h0000;
        step();
        chk("bubble_flags", {13'd0, zf, nf, cf}, 16'h0003);
        chk("bubble_reg_C", reg_C, 16'h0000);
        drive(OP_BN, 16'h0000, 16'h0000);
        #1;
        chk("bn_bt", {15'd0, branch_taken}, 16'h0001);

        // STORE held while the pipeline is stalled.
        drive(OP_STORE, 16'h0010, 16'h0002);
        smdr  = 16'hBEEF;
        state = ~STATE_EXEC;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_dw", {15'd0, dw}, 16'h0000);
            chk("stall_smdr1", smdr1, 16'h1234);
        end
        chk("stall_aluo", ALUo, 16'h0012);
        state = STATE_EXEC;
        step();
        chk("store_dw", {15'd0, dw}, 16'h0001);
        chk("store_smdr1", smdr1, 16'hBEEF);
        chk("store_flags", {13'd0, zf, nf, cf}, 16'h0003);

        // Mid-program reset discards the instruction in EX.
        drive(OP_ADD, 16'h0001, 16'h0001);
        reset = 1'b1;
        step();
        chk("midrst_reg_C", reg_C, 16'h0000);
        chk("midrst_flags_dw", {12'd0, dw, zf, nf, cf}, 16'h0000);
        chk("midrst_mem_ir", mem_ir, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 16-bit five-stage pipeline, directly downstream of instruction decode. It consumes `ex_ir`, `reg_A`, `reg_B` and `smdr` and computes the ALU result and branch decision. It maintains the architectural condition flags and registers results into the MEM-stage latches `mem_ir`, `reg_C`, `smdr1` and `dw`. `ALUo` is combinational so decode can forward it in the same cycle.

## Interface
- No parameters; opcode constants come from the shared define file.
- `clock` in 1: pipeline clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `state` in 1: the pipeline advances only when `state == exec`.
- `ex_ir` in 16: instruction in EX; `16'h0000` is a bubble.
- `reg_A`, `reg_B` in 16 each: operands from decode.
- `smdr` in 16: store data from decode.
- `ALUo` out 16: combinational ALU result.
- `branch_taken` out 1: combinational redirect request to fetch.
- `branch_target` out 16: combinational, equal to `ALUo`.
- `mem_ir` out 16: registered copy of `ex_ir`.
- `reg_C` out 16: registered `ALUo`.
- `smdr1` out 16: registered `smdr`.
- `dw` out 1: registered data-memory write enable.
- `zf`, `nf`, `cf` out 1 each: registered zero, negative and carry flags.

## Operation
- Opcode is `ex_ir[15:11]`. All 16-bit add/sub is done 17 bits wide; bit 16 is the carry.
- ADD, ADDI, LDIH, LOAD, STORE, JMPR and all branches: `ALUo = A + B`.
- ADDC: `ALUo = A + B + cf`.
- SUB, SUBI, CMP: `ALUo = A - B`. SUBC: `ALUo = A - B - cf`.
- Carry after any subtraction is the borrow: `cf = 1` when the unsigned result underflows.
- AND, OR, XOR: bitwise on A and B.
- Shifts use amount `B[3:0]`:
  - SLL and SRL are logical.
  - SLA shifts left but keeps bit 15 equal to `A[15]`.
  - SRA shifts right with sign fill.
- Any other opcode, including the bubble: `ALUo = 16'h0000`.
- Flag update happens on an advancing edge, from the current `ALUo`:
  - ADD, ADDC, ADDI, SUB, SUBC, SUBI, CMP update `zf`, `nf` and `cf`.
  - AND, OR, XOR and the four shifts update `zf` and `nf`; `cf` holds.
  - All other opcodes leave the flags unchanged.
- `branch_taken` is evaluated from the registered flags:
  - BZ when `zf`; BNZ when `!zf`.
  - BN when `nf`; BNN when `!nf`.
  - BC when `cf`; BNC when `!cf`.
  - JMPR always.
  - Any other opcode: 0.
- On each advancing edge:
  - `mem_ir <= ex_ir`, `reg_C <= ALUo`, `smdr1 <= smdr`.
  - `dw <= (opcode == STORE)`.
- Branches, CMP and STORE pass to `mem_ir` unchanged; write-back qualification belongs to later stages.

## Timing
- On reset, all registered outputs and all three flags are cleared to 0 at the next rising edge.
- Reset has priority over `state`.
- Reset asserted mid-program discards the EX instruction; no flag or latch update occurs.
- When `state != exec`, every register holds its value. The combinational outputs still follow their inputs.
- `ALUo`, `branch_taken` and `branch_target` have zero latency. The registered outputs appear one cycle after the instruction is in EX.
- A branch immediately following a flag-setting instruction sees that instruction's flags, because the flags commit on the edge that moves the branch into EX.
- Flag-setting instruction and bubble on consecutive cycles: the bubble does not disturb the flags.
- Fetch flushes on `branch_taken`; this block performs no flushing itself.

## Structure
- Opcode constants and the `exec` state value belong in the shared define file; no new constants are local to this block.
- One combinational sub-module, `ex_alu`:
  - Inputs: opcode, A, B, cf.
  - Outputs: result and carry-out.
- The flag, branch-condition and pipeline-latch logic stays in `ex_stage`.

## Test plan
- Reset held for 2 cycles with random inputs: all registered outputs and flags are 0 throughout.
- ADD with A=`16'hFFFF`, B=`16'h0001`: `ALUo = 16'h0000`; next edge gives `zf = 1`, `cf = 1`, `nf = 0`, `reg_C = 0`.
- SUB with A=`16'h0003`, B=`16'h0005`, then SUBC with A=`16'h0010`, B=`16'h0001`:
  - SUB gives `reg_C = 16'hFFFE`, `nf = 1`, `cf = 1`.
  - SUBC gives `reg_C = 16'h000E`.
- SRA with A=`16'h8000`, B=4 gives `16'hF800`. SLA with A=`16'h8001`, B=1 gives `16'h8002`.
- CMP A=B=`16'h0007`, then BZ with A=`16'h0100`, B=`16'h0004`: `branch_taken = 1`, `branch_target = 16'h0104`. A following BNZ gives `branch_taken = 0`.
- STORE with `smdr = 16'hBEEF` while `state != exec` for 3 cycles: `dw` stays 0. Once `state` returns to `exec`, the next edge gives `dw = 1`, `smdr1 = 16'hBEEF`.
